memory_stage_p: RTL

//  Parametrised MEM stage for the pipelined MIPS core. It sits between EX and WB and feeds the *_ME pipeline registers.

---
 rtl/memory_stage_p.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/memory_stage_p.sv
// memory_stage_p
//   MEM stage of the pipelined MIPS core, between EX and WB. It owns the data
//   RAM, performs byte/half/word loads and stores, flags misaligned accesses,
//   and can add MEM_LAT wait cycles per access. While it waits it raises
//   MemBusy so the hazard unit can stall the rest of the pipeline.
//
// Parameters
//   ADDR_W   word-address bits, RAM depth is 2**ADDR_W words of 32 bits
//   MEM_LAT  extra wait cycles per load/store (0..7)
//
// Ports
//   clk, reset            clock and synchronous active-high reset
//   flush                 squashes the ME registers and any in-flight access
//   AnyStall              pipeline stall from the hazard unit
//   Result_EX, WrDat_EX   byte address / ALU result and store data from EX
//   RegWrite_EX, MemToReg_EX, MemWrite_EX, MemSize_EX, MemSigned_EX,
//   WriteReg_EX           EX control fields
//   RdDat_ME, Result_ME, WriteReg_ME, RegWrite_ME, MemToReg_ME, MisAlign_ME
//                         registered ME pipeline outputs
//   MemBusy               combinational stall request to the hazard unit
module memory_stage_p #(
  parameter int ADDR_W  = 6,
  parameter int MEM_LAT = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic        AnyStall,
  input  logic [31:0] Result_EX,
  input  logic [31:0] WrDat_EX,
  input  logic        RegWrite_EX,
  input  logic        MemToReg_EX,
  input  logic        MemWrite_EX,
  input  logic [1:0]  MemSize_EX,
  input  logic        MemSigned_EX,
  input  logic [4:0]  WriteReg_EX,
  output logic [31:0] RdDat_ME,
  output logic [31:0] Result_ME,
  output logic [4:0]  WriteReg_ME,
  output logic        RegWrite_ME,
  output logic        MemToReg_ME,
  output logic        MisAlign_ME,
  output logic        MemBusy
);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  localparam bit         HAS_LAT  = (MEM_LAT > 0);
  localparam logic [2:0] LAT_INIT = HAS_LAT ? 3'(MEM_LAT - 1) : 3'd0;

  logic [31:0]       ram [2**ADDR_W];
  state_t            state;
  logic [2:0]        cnt;
  logic [31:0]       holdQ;

  logic [ADDR_W-1:0] wordIdx;
  logic [1:0]        lane;
  logic              access;
  logic              misAlign;
  logic              startWait;
  logic              commit;
  logic              ramWe;
  logic              meLoad;
  logic              meMis;
  logic [31:0]       meRd;
  logic [31:0]       rdWord;
  logic [7:0]        byteVal;
  logic [15:0]       halfVal;
  logic [31:0]       loadData;
  logic [31:0]       storeData;

  // Address decode and misalignment: halves need a[0]=0, words need a[1:0]=0.
  always_comb begin
    wordIdx   = Result_EX[ADDR_W+1:2];
    lane      = Result_EX[1:0];
    access    = MemToReg_EX | MemWrite_EX;
    misAlign  = access & (((MemSize_EX == 2'b01) & lane[0]) |
                          (MemSize_EX[1] & (lane != 2'b00)));
    startWait = HAS_LAT & access & ~misAlign;
    commit    = (state == WAIT) & (cnt == 3'd0);
  end

  // Load path: pick the addressed lane(s) out of the word, then extend.
  // Store path: read-modify-write merge of the new lane(s) into the old word.
  always_comb begin
    rdWord    = ram[wordIdx];
    byteVal   = rdWord[{lane, 3'b000} +: 8];
    halfVal   = rdWord[{lane[1], 4'b0000} +: 16];
    loadData  = rdWord;
    storeData = rdWord;
    case (MemSize_EX)
      2'b00: begin
        loadData = {{24{MemSigned_EX & byteVal[7]}}, byteVal};
        storeData[{lane, 3'b000} +: 8] = WrDat_EX[7:0];
      end
      2'b01: begin
        loadData = {{16{MemSigned_EX & halfVal[15]}}, halfVal};
        storeData[{lane[1], 4'b0000} +: 16] = WrDat_EX[15:0];
      end
      default: begin
        loadData  = rdWord;
        storeData = WrDat_EX;
      end
    endcase
  end

  // Handshake decisions. An IDLE store only writes when it retires in the
  // same cycle (no latency, not stalled); a latency store writes only at the
  // commit point, so a flush or reset before commit drops it cleanly.
  always_comb begin
    MemBusy = ~reset & (((state == IDLE) & startWait) |
                        ((state == WAIT) & (cnt != 3'd0)));
    ramWe   = ~reset & ~flush & MemWrite_EX &
              (((state == IDLE) & ~startWait & ~AnyStall & ~misAlign) | commit);
    meLoad  = ~AnyStall & (((state == IDLE) & ~startWait) | commit | (state == DONE));
    meRd    = (state == DONE) ? holdQ : loadData;
    meMis   = (state == IDLE) & misAlign;
  end

  // Data RAM, intentionally without reset.
  always_ff @(posedge clk) begin
    if (ramWe) begin
      ram[wordIdx] <= storeData;
    end
  end

  // Access FSM and ME pipeline registers. A misaligned access never writes
  // back, so its RegWrite is dropped here rather than in WB.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= 3'd0;
      holdQ       <= 32'd0;
      RdDat_ME    <= 32'd0;
      Result_ME   <= 32'd0;
      WriteReg_ME <= 5'd0;
      RegWrite_ME <= 1'b0;
      MemToReg_ME <= 1'b0;
      MisAlign_ME <= 1'b0;
    end else if (flush) begin
      state       <= IDLE;
      cnt         <= 3'd0;
      RdDat_ME    <= 32'd0;
      Result_ME   <= 32'd0;
      WriteReg_ME <= 5'd0;
      RegWrite_ME <= 1'b0;
      MemToReg_ME <= 1'b0;
      MisAlign_ME <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (startWait) begin
            cnt   <= LAT_INIT;
            state <= WAIT;
          end
        end
        WAIT: begin
          if (cnt != 3'd0) begin
            cnt <= cnt - 3'd1;
          end else begin
            holdQ <= loadData;
            state <= AnyStall ? DONE : IDLE;
          end
        end
        DONE: begin
          if (!AnyStall) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
      if (meLoad) begin
        RdDat_ME    <= meRd;
        Result_ME   <= Result_EX;
        WriteReg_ME <= WriteReg_EX;
        RegWrite_ME <= RegWrite_EX & ~meMis;
        MemToReg_ME <= MemToReg_EX;
        MisAlign_ME <= meMis;
      end
    end
  end

endmodule
